// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-flight branch prediction queue between fetch and execute.
// Holds predicted directions in a circular FIFO, pops the oldest on resolve and
// emits registered predictor-update, mispredict and error pulses.
// Optional statistics counters are built only when BRQ_STATS_EN is defined.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pred_valid,
  input  logic                     pred_taken,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     upd_en,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic                     res_err,
`ifdef BRQ_STATS_EN
  output logic [CNT_W-1:0]         stat_branches,
  output logic [CNT_W-1:0]         stat_mispred,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_enq;
  logic             do_pop;
  logic             do_flush;
  logic             head;

  // Handshake and resolve decode; readiness depends on occupancy alone
  always_comb begin
    pred_ready = (count != FULL);
    head       = mem[rd_ptr];
    do_enq     = pred_valid && pred_ready;
    do_pop     = res_valid && (count != '0);
    do_flush   = do_pop && (head != res_taken);
  end

  // Queue storage, pointers, occupancy and registered resolve pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      upd_en     <= 1'b0;
      upd_taken  <= 1'b0;
      mispredict <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      upd_en     <= do_pop;
      mispredict <= do_flush;
      res_err    <= res_valid && (count == '0);
      if (do_pop) begin
        upd_taken <= res_taken;
      end
      if (do_flush) begin
        // A wrong prediction invalidates everything younger, including this cycle's fetch
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_enq) begin
          mem[wr_ptr] <= pred_taken;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count <= count + CW'(do_enq) - CW'(do_pop);
      end
    end
  end

`ifdef BRQ_STATS_EN
  // Saturating totals of resolved branches and mispredictions
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (do_pop && (stat_branches != '1)) begin
        stat_branches <= stat_branches + CNT_W'(1);
      end
      if (do_flush && (stat_mispred != '1)) begin
        stat_mispred <= stat_mispred + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed scenarios plus randomized traffic for
// branch_resolve_queue, checked against a queue-based reference model.
// Define BRQ_STATS_EN to also exercise the statistics counters.
module tb_branch_resolve_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pred_valid;
  logic       pred_taken;
  logic       pred_ready;
  logic       res_valid;
  logic       res_taken;
  logic       upd_en;
  logic       upd_taken;
  logic       mispredict;
  logic       res_err;
  logic [2:0] count;
`ifdef BRQ_STATS_EN
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_mispred;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit q[$];
  bit exp_upd_en;
  bit exp_upd_taken;
  bit exp_mis;
  bit exp_err;
  int exp_branches;
  int exp_mispred;

  branch_resolve_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pred_valid(pred_valid),
    .pred_taken(pred_taken),
    .pred_ready(pred_ready),
    .res_valid(res_valid),
    .res_taken(res_taken),
    .upd_en(upd_en),
    .upd_taken(upd_taken),
    .mispredict(mispredict),
    .res_err(res_err),
`ifdef BRQ_STATS_EN
    .stat_branches(stat_branches),
    .stat_mispred(stat_mispred),
`endif
    .count(count)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("count", int'(count), q.size());
    checkOutput("upd_en", int'(upd_en), int'(exp_upd_en));
    if (exp_upd_en) checkOutput("upd_taken", int'(upd_taken), int'(exp_upd_taken));
    checkOutput("mispredict", int'(mispredict), int'(exp_mis));
    checkOutput("res_err", int'(res_err), int'(exp_err));
`ifdef BRQ_STATS_EN
    checkOutput("stat_branches", int'(stat_branches), exp_branches);
    checkOutput("stat_mispred", int'(stat_mispred), exp_mispred);
`endif
  endtask

  // One cycle: drive at negedge, check ready, update model at posedge, check at next negedge
  task automatic applyStimulus(input bit rn, input bit pv, input bit pt, input bit rv, input bit rt);
    bit exp_ready;
    bit enq;
    bit pop;
    bit mis;
    int maxc;
    rst_n      = rn;
    pred_valid = pv;
    pred_taken = pt;
    res_valid  = rv;
    res_taken  = rt;
    #1;
    exp_ready = (q.size() != DEPTH);
    if (rn) checkOutput("pred_ready", int'(pred_ready), int'(exp_ready));
    @(posedge clk);
    maxc = (1 << CNT_W) - 1;
    if (!rn) begin
      q.delete();
      exp_upd_en = 0;
      exp_upd_taken = 0;
      exp_mis = 0;
      exp_err = 0;
      exp_branches = 0;
      exp_mispred = 0;
    end else begin
      enq = pv && exp_ready;
      pop = rv && (q.size() > 0);
      exp_err = rv && (q.size() == 0);
      mis = 0;
      if (pop) begin
        mis = (q[0] != rt);
        exp_upd_taken = rt;
        if (exp_branches < maxc) exp_branches++;
        if (mis && exp_mispred < maxc) exp_mispred++;
        if (mis) q.delete();
        else void'(q.pop_front());
      end
      exp_upd_en = pop;
      exp_mis = mis;
      if (enq && !mis) q.push_back(pt);
    end
    @(negedge clk);
    checkAll();
  endtask

  function automatic bit headOr(input bit fallback);
    return (q.size() > 0) ? q[0] : fallback;
  endfunction

  initial begin
    rst_n = 1'b0;
    pred_valid = 1'b0;
    pred_taken = 1'b0;
    res_valid = 1'b0;
    res_taken = 1'b0;
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 1);
    checkOutput("reset_ready", int'(pred_ready), 1);

    // Enqueue T,N,T then resolve 1,0,1 with no mispredictions
    applyStimulus(1, 1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 1);
    checkOutput("seq_upd_t1", int'(upd_taken), 1);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("seq_upd_t0", int'(upd_taken), 0);
    applyStimulus(1, 0, 0, 1, 1);
    checkOutput("seq_mis", int'(mispredict), 0);
    checkOutput("seq_count", int'(count), 0);
    applyStimulus(1, 0, 0, 0, 0);

    // Fill past capacity, then drain with correct outcomes to wrap pointers
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 1'($urandom_range(0, 1)), 0, 0);
    checkOutput("full_count", int'(count), 4);
    checkOutput("full_ready", int'(pred_ready), 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 1, headOr(0));
    checkOutput("drain_count", int'(count), 0);

    // Mispredict flush: queue 1,1,0 resolved with 0
    applyStimulus(1, 1, 1, 0, 0);
    applyStimulus(1, 1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 1, 0);
    checkOutput("flush_mis", int'(mispredict), 1);
    checkOutput("flush_upd", int'(upd_taken), 0);
    checkOutput("flush_count", int'(count), 0);

    // Resolve on empty queue with simultaneous enqueue
    applyStimulus(1, 1, 1, 1, 1);
    checkOutput("empty_err", int'(res_err), 1);
    checkOutput("empty_upd", int'(upd_en), 0);
    checkOutput("empty_count", int'(count), 1);

    // Reset mid-operation with three entries
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0);
    checkOutput("pre_rst_count", int'(count), 3);
    applyStimulus(0, 1, 1, 1, 0);
    checkOutput("rst_count", int'(count), 0);
    checkOutput("rst_upd", int'(upd_en), 0);

`ifdef BRQ_STATS_EN
    // Drive counters into saturation
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 1, 1, 0, 0);
      applyStimulus(1, 0, 0, 1, 0);
    end
    checkOutput("sat_branches", int'(stat_branches), 15);
    checkOutput("sat_mispred", int'(stat_mispred), 15);
    applyStimulus(0, 0, 0, 0, 0);
`endif

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      bit rt;
      rt = ($urandom_range(0, 3) != 0) ? headOr(1'($urandom_range(0, 1))) : 1'($urandom_range(0, 1));
      applyStimulus(($urandom_range(0, 49) != 0),
                    ($urandom_range(0, 9) < 6),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) == 1),
                    rt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
